hc283_seq_ctrl: RTL and testbench

//  Sequencer that drives one shared combinational 4-bit adder (hc283-style: a, b, cin -> sum, cout).

---
 rtl/hc283_seq_if.sv | 45 ++++
 rtl/hc283_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_hc283_seq_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/hc283_seq_if.sv
// Front-end and adder-side signal bundle for the nibble-serial hc283 sequencer.
// HC283_SEQ_SUB_EN adds the 'sub' request bit to the bundle.
interface hc283_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         cin;
`ifdef HC283_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;

`ifdef HC283_SEQ_SUB_EN
    modport slave (
        input  start, opA, opB, cin, sub, add_sum, add_cout,
        output busy, done, result, cout, add_a, add_b, add_cin
    );
    modport master (
        output start, opA, opB, cin, sub, add_sum, add_cout,
        input  busy, done, result, cout, add_a, add_b, add_cin
    );
`else
    modport slave (
        input  start, opA, opB, cin, add_sum, add_cout,
        output busy, done, result, cout, add_a, add_b, add_cin
    );
    modport master (
        output start, opA, opB, cin, add_sum, add_cout,
        input  busy, done, result, cout, add_a, add_b, add_cin
    );
`endif

endinterface

// File: rtl/hc283_seq_ctrl.sv
// Nibble-serial add sequencer around one shared 4-bit hc283-style adder.
// Optional HC283_SEQ_SUB_EN enables A-B via inverted B and forced carry-in.
//
//  state  | meaning
//  S_IDLE | waiting for start; adder inputs held at 0
//  S_RUN  | one nibble captured per clock, carry rippled in 'carry'
//  S_DONE | result/cout valid, done high; start here re-launches immediately
module hc283_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    hc283_seq_if.slave   bus
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES) + 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [IDXW-1:0] idx;
    logic           carry;
    logic [W-1:0]   a_lat;
    logic [W-1:0]   b_lat;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   result_q;
    logic           cout_q;
    logic           accept;
    logic           init_carry;
    logic [IDXW+1:0] nib_base;
    logic [3:0]     b_nib;

`ifdef HC283_SEQ_SUB_EN
    logic           sub_lat;
    // Subtraction is A + ~B + 1, so cin is ignored when sub is requested.
    assign init_carry = bus.sub ? 1'b1 : bus.cin;
`else
    assign init_carry = bus.cin;
`endif

    assign accept   = bus.start && (state != S_RUN);
    assign nib_base = {idx, 2'b00};

    always_comb begin
        bus.add_a   = 4'h0;
        bus.add_b   = 4'h0;
        bus.add_cin = 1'b0;
        b_nib       = b_lat[nib_base +: 4];
`ifdef HC283_SEQ_SUB_EN
        if (sub_lat) begin
            b_nib = ~b_lat[nib_base +: 4];
        end
`endif
        if (state == S_RUN) begin
            bus.add_a   = a_lat[nib_base +: 4];
            bus.add_b   = b_nib;
            bus.add_cin = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_lat    <= '0;
            b_lat    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef HC283_SEQ_SUB_EN
            sub_lat  <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    result_q[nib_base +: 4] <= bus.add_sum;
                    carry                   <= bus.add_cout;
                    if (idx == LAST) begin
                        cout_q <= bus.add_cout;
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        a_lat    <= bus.opA;
                        b_lat    <= bus.opB;
                        carry    <= init_carry;
                        idx      <= '0;
                        result_q <= '0;
                        state    <= S_RUN;
                        busy_q   <= 1'b1;
`ifdef HC283_SEQ_SUB_EN
                        sub_lat  <= bus.sub;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

endmodule

// File: tb/tb_hc283_seq_ctrl.sv
// Directed bench for hc283_seq_ctrl (NIBBLES=4) with a behavioural 4-bit adder
// and a done-driven scoreboard; HC283_SEQ_SUB_EN also exercises subtraction.
module tb_hc283_seq_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic clk;
    logic rst_n;

    hc283_seq_if #(.NIBBLES(NIBBLES)) bus ();

    hc283_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The external hc283 adder.
    assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [W:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W-1:0] bb;
        bb = b;
        if (s) return {1'b0, a} + {1'b0, ~bb} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_done: observed done=1 expected no pending op");
            end else begin
                chk("result_cout", {15'd0, bus.cout, bus.result}, {15'd0, sb.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input logic st);
        bus.opA   = a;
        bus.opB   = b;
        bus.cin   = c;
`ifdef HC283_SEQ_SUB_EN
        bus.sub   = s;
`endif
        bus.start = st;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s);
        drive(a, b, c, s, 1'b1);
        sb.push_back(model(a, b, c, s));
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) return;
            cyc();
        end
        checks++;
        errors++;
        $error("FAIL %s: observed no done in 20 cycles expected done", tag);
    endtask

    int d0;

    initial begin
        rst_n = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_result", bus.result, 0);
        chk("rst_cout",   bus.cout,   0);
        chk("rst_add",    {bus.add_a, bus.add_b, bus.add_cin}, 0);
        rst_n = 1'b1;
        cyc();

        // 1: basic add, latency and busy window
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        chk("t1_add_a0", bus.add_a, 4'h4);
        chk("t1_add_b0", bus.add_b, 4'h1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_busy", bus.busy, 1);
            chk("t1_nodone", bus.done, 0);
            cyc();
        end
        chk("t1_done", bus.done, 1);
        chk("t1_busy_off", bus.busy, 0);
        cyc();
        chk("t1_done_pulse", bus.done, 0);
        chk("t1_hold", bus.result, 16'h5555);
        chk("t1_idle_add", {bus.add_a, bus.add_b, bus.add_cin}, 0);

        // 2: full ripple
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("t2_cin0", bus.add_cin, 0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("t2_cin_ripple", bus.add_cin, 1);
        end
        cyc();
        chk("t2_done", bus.done, 1);
        cyc();

        // 3: cin=1 with carry out, then back-to-back via held start
        drive(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
        sb.push_back(model(16'h8000, 16'h8000, 1'b1, 1'b0));
        cyc();
        drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        sb.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) cyc();
        chk("t3_done1", bus.done, 1);
        cyc();
        chk("t3_b2b_busy", bus.busy, 1);
        chk("t3_b2b_done", bus.done, 0);
        bus.start = 1'b0;
        wait_done("t3_second");
        cyc();

        // 4: start and operand changes during RUN are ignored
        d0 = done_cnt;
        issue(16'h000F, 16'h0001, 1'b0, 1'b0);
        cyc();
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("t4_one_done", done_cnt - d0, 1);
        chk("t4_not_queued", bus.busy, 0);

        // 5: reset mid-operation aborts it without a done
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("t5_busy",   bus.busy,   0);
        chk("t5_done",   bus.done,   0);
        chk("t5_result", bus.result, 0);
        chk("t5_cout",   bus.cout,   0);
        chk("t5_add",    {bus.add_a, bus.add_b, bus.add_cin}, 0);
        rst_n = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) cyc();
        chk("t5_no_done", done_cnt - d0, 0);
        issue(16'h0100, 16'h0200, 1'b0, 1'b0);
        wait_done("t5_after_reset");
        cyc();

`ifdef HC283_SEQ_SUB_EN
        // 6: subtraction, with cin ignored, and sub=0 fallback
        issue(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_done("t6_sub_a");
        cyc();
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done("t6_sub_b");
        cyc();
        chk("t6_borrow", bus.result, 16'hFFFE);
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done("t6_add");
        cyc();
`endif

        cyc();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
